// File: rtl/rc4_phase_sched_if.sv
// Phase handshakes and S-memory port shared between the RC4 sequencer,
// its populate/shuffle/decode sub-blocks and the 256x8 S memory.
interface rc4_phase_sched_if;
  logic       pop_start;
  logic       pop_finish;
  logic [7:0] pop_addr;
  logic [7:0] pop_data;
  logic       pop_wren;

  logic       shf_start;
  logic       shf_finish;
  logic [7:0] shf_addr;
  logic [7:0] shf_data;
  logic       shf_wren;

  logic       dec_start;
  logic       dec_finish;
  logic       dec_ok;
  logic [7:0] dec_addr;
  logic [7:0] dec_data;
  logic       dec_wren;

  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wren;

  modport master (
    output pop_start, shf_start, dec_start,
    output s_addr, s_data, s_wren,
    input  pop_finish, pop_addr, pop_data, pop_wren,
    input  shf_finish, shf_addr, shf_data, shf_wren,
    input  dec_finish, dec_ok, dec_addr, dec_data, dec_wren
  );

  modport slave (
    input  pop_start, shf_start, dec_start,
    input  s_addr, s_data, s_wren,
    output pop_finish, pop_addr, pop_data, pop_wren,
    output shf_finish, shf_addr, shf_data, shf_wren,
    output dec_finish, dec_ok, dec_addr, dec_data, dec_wren
  );
endinterface

// File: rtl/rc4_phase_sched.sv
// RC4 key-search sequencer: runs populate, shuffle and decode per
// candidate key and owns the single S-memory port.
module rc4_phase_sched #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  rc4_phase_sched_if.master ph,
  output logic [KEY_W-1:0] key_out,
  output logic             busy,
  output logic             done,
  output logic             found
);

  typedef enum logic [3:0] {
    IDLE,
    POP_GO,
    POP_WAIT,
    SHF_GO,
    SHF_WAIT,
    DEC_GO,
    DEC_WAIT,
    NEXT_KEY,
    DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [KEY_W-1:0] key_d;
  logic             found_d;

  // Next state, next key and result flag; finish pulses only count in WAIT.
  always_comb begin
    state_d = state;
    key_d   = key_out;
    found_d = found;
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          state_d = POP_GO;
          key_d   = KEY_START;
          found_d = 1'b0;
        end
      end
      POP_GO: state_d = POP_WAIT;
      POP_WAIT: begin
        if (ph.pop_finish) state_d = SHF_GO;
      end
      SHF_GO: state_d = SHF_WAIT;
      SHF_WAIT: begin
        if (ph.shf_finish) state_d = DEC_GO;
      end
      DEC_GO: state_d = DEC_WAIT;
      DEC_WAIT: begin
        if (ph.dec_finish) begin
          if (ph.dec_ok) begin
            found_d = 1'b1;
            state_d = DONE;
          end else if (key_out == KEY_MAX) begin
            found_d = 1'b0;
            state_d = DONE;
          end else begin
            state_d = NEXT_KEY;
          end
        end
      end
      NEXT_KEY: begin
        key_d   = key_out + KEY_W'(1);
        state_d = POP_GO;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, key and registered status/strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      key_out      <= KEY_START;
      found        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ph.pop_start <= 1'b0;
      ph.shf_start <= 1'b0;
      ph.dec_start <= 1'b0;
    end else begin
      state        <= state_d;
      key_out      <= key_d;
      found        <= found_d;
      busy         <= !(state_d == IDLE || state_d == DONE);
      done         <= (state_d == DONE);
      ph.pop_start <= (state_d == POP_GO);
      ph.shf_start <= (state_d == SHF_GO);
      ph.dec_start <= (state_d == DEC_GO);
    end
  end

  // S-memory port goes to the active phase only; idle states park at zero.
  always_comb begin
    ph.s_addr = '0;
    ph.s_data = '0;
    ph.s_wren = 1'b0;
    unique case (state)
      POP_GO, POP_WAIT: begin
        ph.s_addr = ph.pop_addr;
        ph.s_data = ph.pop_data;
        ph.s_wren = ph.pop_wren;
      end
      SHF_GO, SHF_WAIT: begin
        ph.s_addr = ph.shf_addr;
        ph.s_data = ph.shf_data;
        ph.s_wren = ph.shf_wren;
      end
      DEC_GO, DEC_WAIT: begin
        ph.s_addr = ph.dec_addr;
        ph.s_data = ph.dec_data;
        ph.s_wren = ph.dec_wren;
      end
      default: begin
        ph.s_addr = '0;
        ph.s_data = '0;
        ph.s_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Bench for rc4_phase_sched: modelled sub-blocks answer each start
// pulse while the S-port mux and search result are checked.
module tb_rc4_phase_sched;
  localparam int KW = 8;
  localparam int NK = 4;

  typedef struct {
    logic [3:0] mask;
    int         dly;
    bit         early;
    bit         f;
    int         key;
    int         rounds;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [KW-1:0] key_out;
  logic          busy;
  logic          done;
  logic          found;

  int checks = 0;
  int fails  = 0;
  int starts [3];

  rc4_phase_sched_if bus ();

  rc4_phase_sched #(
    .KEY_W    (KW),
    .KEY_START(8'd0),
    .KEY_MAX  (8'd3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .ph     (bus),
    .key_out(key_out),
    .busy   (busy),
    .done   (done),
    .found  (found)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic start_of(input int p);
    case (p)
      0:       return bus.pop_start;
      1:       return bus.shf_start;
      default: return bus.dec_start;
    endcase
  endfunction

  task automatic clr_fin();
    bus.pop_finish = 1'b0;
    bus.shf_finish = 1'b0;
    bus.dec_finish = 1'b0;
    bus.dec_ok     = 1'b0;
  endtask

  task automatic clr_all();
    clr_fin();
    bus.pop_addr = '0; bus.pop_data = '0; bus.pop_wren = 1'b0;
    bus.shf_addr = '0; bus.shf_data = '0; bus.shf_wren = 1'b0;
    bus.dec_addr = '0; bus.dec_data = '0; bus.dec_wren = 1'b0;
  endtask

  task automatic set_fin(input int p, input logic v, input logic ok);
    case (p)
      0: bus.pop_finish = v;
      1: bus.shf_finish = v;
      default: begin
        bus.dec_finish = v;
        bus.dec_ok     = ok;
      end
    endcase
  endtask

  // random requester traffic plus stray finishes from inactive phases
  task automatic rand_traffic(input int p);
    bus.pop_addr   = 8'($urandom);
    bus.pop_data   = 8'($urandom);
    bus.pop_wren   = 1'($urandom_range(0, 1));
    bus.shf_addr   = 8'($urandom);
    bus.shf_data   = 8'($urandom);
    bus.shf_wren   = 1'($urandom_range(0, 1));
    bus.dec_addr   = 8'($urandom);
    bus.dec_data   = 8'($urandom);
    bus.dec_wren   = 1'($urandom_range(0, 1));
    bus.pop_finish = (p != 0) && ($urandom_range(0, 3) == 0);
    bus.shf_finish = (p != 1) && ($urandom_range(0, 3) == 0);
    bus.dec_finish = (p != 2) && ($urandom_range(0, 3) == 0);
    bus.dec_ok     = 1'($urandom_range(0, 1));
  endtask

  task automatic check_mux(input int p);
    logic [7:0] ea;
    logic [7:0] ed;
    logic       ew;
    case (p)
      0: begin ea = bus.pop_addr; ed = bus.pop_data; ew = bus.pop_wren; end
      1: begin ea = bus.shf_addr; ed = bus.shf_data; ew = bus.shf_wren; end
      2: begin ea = bus.dec_addr; ed = bus.dec_data; ew = bus.dec_wren; end
      default: begin ea = '0; ed = '0; ew = 1'b0; end
    endcase
    chk("s_addr", bus.s_addr, ea);
    chk("s_data", bus.s_data, ed);
    chk("s_wren", bus.s_wren, ew);
  endtask

  // play one sub-block: wait for its start, hold dly WAIT cycles, finish
  task automatic serve(input int p, input int dly, input logic ok,
                       input bit early, input int exp_key, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (start_of(p) !== 1'b1) begin
      if (n == 40) begin
        chk("start_wait", 0, 1);
        to = 1'b1;
        return;
      end
      @(negedge clk);
      n++;
    end
    starts[p]++;
    chk("key_in_round", key_out, exp_key);
    chk("busy_run", busy, 1);
    rand_traffic(p);
    #1;
    check_mux(p);
    if (early) set_fin(p, 1'b1, ok);
    @(negedge clk);
    set_fin(p, 1'b0, 1'b0);
    chk("start_one_cycle", start_of(p), 0);
    for (int i = 0; i < dly; i++) begin
      rand_traffic(p);
      #1;
      check_mux(p);
      if (i == dly - 1) set_fin(p, 1'b1, ok);
      @(negedge clk);
    end
    clr_fin();
  endtask

  // first passing key in the range wins; none passing ends on the last key
  function automatic void model(input logic [3:0] mask, output bit f,
                                output int key, output int rounds);
    f      = 1'b0;
    key    = NK - 1;
    rounds = NK;
    for (int i = NK - 1; i >= 0; i--) begin
      if (mask[i]) begin
        f      = 1'b1;
        key    = i;
        rounds = i + 1;
      end
    end
  endfunction

  task automatic run_search(input vec_t v);
    bit t;
    t      = 1'b0;
    starts = '{0, 0, 0};
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_to_pop_start", bus.pop_start, 1);
    for (int r = 0; r < NK; r++) begin
      serve(0, v.dly, 1'b0, v.early, r, t);
      if (t) break;
      serve(1, v.dly, 1'b0, v.early, r, t);
      if (t) break;
      serve(2, v.dly, v.mask[r], v.early, r, t);
      if (t) break;
      if (done) break;
    end
    chk("done", done, 1);
    chk("found", found, 32'(v.f));
    chk("key_final", key_out, v.key);
    chk("busy_done", busy, 0);
    chk("s_wren_done", bus.s_wren, 0);
    chk("pop_rounds", starts[0], v.rounds);
    chk("dec_rounds", starts[2], v.rounds);
  endtask

  initial begin
    vec_t tbl [5];
    vec_t rv;
    bit   tmo;
    int   n;

    tbl[0] = '{4'b0001, 5, 1'b0, 1'b1, 0, 1};
    tbl[1] = '{4'b0000, 5, 1'b0, 1'b0, 3, 4};
    tbl[2] = '{4'b1000, 1, 1'b1, 1'b1, 3, 4};
    tbl[3] = '{4'b0110, 2, 1'b0, 1'b1, 1, 2};
    tbl[4] = '{4'b0100, 3, 1'b1, 1'b1, 2, 3};

    rst = 1'b1;
    go  = 1'b0;
    clr_all();
    repeat (2) @(negedge clk);
    chk("rst_key", key_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_pop_start", bus.pop_start, 0);
    chk("rst_s_wren", bus.s_wren, 0);
    rst = 1'b0;
    @(negedge clk);

    // IDLE parks the S port whatever the requesters drive
    bus.pop_wren = 1'b1; bus.pop_addr = 8'h11;
    bus.shf_wren = 1'b1; bus.shf_addr = 8'h22;
    bus.dec_wren = 1'b1; bus.dec_addr = 8'h33;
    #1;
    chk("idle_s_wren", bus.s_wren, 0);
    chk("idle_s_addr", bus.s_addr, 0);
    @(negedge clk);
    clr_all();

    foreach (tbl[i]) run_search(tbl[i]);

    // go in DONE restarts from KEY_START with found cleared
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("restart_found", found, 0);
    chk("restart_key", key_out, 0);
    chk("restart_done", done, 0);
    chk("restart_pop_start", bus.pop_start, 1);
    @(negedge clk);
    chk("pop_start_drop", bus.pop_start, 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("go_busy_ignored", bus.pop_start, 0);
    chk("go_busy_key", key_out, 0);
    // POP_WAIT: foreign writes and a stray decode finish go nowhere
    bus.pop_addr = 8'h12; bus.pop_data = 8'h34; bus.pop_wren = 1'b1;
    bus.shf_addr = 8'h55; bus.shf_wren = 1'b1;
    bus.dec_finish = 1'b1; bus.dec_ok = 1'b1;
    #1;
    chk("pw_s_addr", bus.s_addr, 8'h12);
    chk("pw_s_data", bus.s_data, 8'h34);
    chk("pw_s_wren", bus.s_wren, 1);
    @(negedge clk);
    clr_fin();
    chk("stray_shf_start", bus.shf_start, 0);
    chk("stray_dec_start", bus.dec_start, 0);
    chk("stray_done", done, 0);
    bus.pop_wren = 1'b0;
    #1;
    chk("pw_s_wren_low", bus.s_wren, 0);
    set_fin(0, 1'b1, 1'b0);
    @(negedge clk);
    clr_fin();
    serve(1, 2, 1'b0, 1'b0, 0, tmo);
    serve(2, 2, 1'b1, 1'b0, 0, tmo);
    chk("stray_seq_found", found, 1);
    chk("stray_seq_key", key_out, 0);

    // reset in SHF_WAIT of the second key
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    serve(0, 2, 1'b0, 1'b0, 0, tmo);
    serve(1, 2, 1'b0, 1'b0, 0, tmo);
    serve(2, 2, 1'b0, 1'b0, 0, tmo);
    serve(0, 2, 1'b0, 1'b0, 1, tmo);
    n = 0;
    while (bus.shf_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("shf_start_seen", bus.shf_start, 1);
    @(negedge clk);
    bus.shf_wren = 1'b1;
    bus.shf_addr = 8'h77;
    #1;
    chk("pre_rst_s_wren", bus.s_wren, 1);
    chk("pre_rst_key", key_out, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_s_wren", bus.s_wren, 0);
    chk("async_s_addr", bus.s_addr, 0);
    chk("async_busy", busy, 0);
    chk("async_key", key_out, 0);
    chk("async_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    clr_all();
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      rv.mask  = 4'($urandom_range(0, 15));
      rv.dly   = $urandom_range(1, 6);
      rv.early = 1'($urandom_range(0, 1));
      model(rv.mask, rv.f, rv.key, rv.rounds);
      run_search(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
